// File: rtl/pmod_cfg_pkg.sv
// pmod_cfg_pkg: shared types and constants for the pmod_controller configuration
// sequencer.
//   state_t        sequencer FSM states
//   ERR_*          err_code encodings reported on completion
//   AXI_RESP_OKAY  AXI response code for a successful transfer
//   idx_width()    width of a register index for a bank of n registers (min 1)
package pmod_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        FINISH
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RESP     = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pmod_cfg_timeout.sv
// pmod_cfg_timeout: stall watchdog for one handshake phase.
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         high in the first cycle of a new phase; restarts the count
//   en          high while a phase that may stall is active
//   expired     high in the cycle where the phase has stalled TIMEOUT_CYCLES cycles
module pmod_cfg_timeout #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // The cycle carrying clr counts as stall cycle 0, so the register is
    // loaded with 1 there and cnt equals the elapsed stall count afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CW'(1);
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && !clr && (cnt == LIMIT);

endmodule

// File: rtl/pmod_cfg_sequencer.sv
// pmod_cfg_sequencer: AXI4-Lite master that writes cfg_data into NUM_REGS
// consecutive pmod_controller registers after a single start pulse.
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   start                one-cycle request to begin a sequence (ignored while busy)
//   cfg_data             register values, word i at [32*i+31:32*i]
//   busy, done           sequence in progress / one-cycle completion pulse
//   err_code, err_idx    result of the last sequence and failing register index
//   M_AXI_AW*/W*/B*      write channels
//   M_AXI_AR*/R*         read channels (used only for readback verification)
// Build option: define PMOD_CFG_VERIFY_EN to read every register back after
// the writes and compare it with the value written. Without it the read
// channels are tied off and err_code=2 never occurs.
module pmod_cfg_sequencer
    import pmod_cfg_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS           = 4,
    parameter int BASE_ADDR          = 0,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                                ACLK,
    input  logic                                ARESETN,
    input  logic                                start,
    input  logic [NUM_REGS*32-1:0]              cfg_data,
    output logic                                busy,
    output logic                                done,
    output logic [1:0]                          err_code,
    output logic [idx_width(NUM_REGS)-1:0]      err_idx,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]       M_AXI_AWADDR,
    output logic [2:0]                          M_AXI_AWPROT,
    output logic                                M_AXI_AWVALID,
    input  logic                                M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]       M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]     M_AXI_WSTRB,
    output logic                                M_AXI_WVALID,
    input  logic                                M_AXI_WREADY,
    input  logic [1:0]                          M_AXI_BRESP,
    input  logic                                M_AXI_BVALID,
    output logic                                M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]       M_AXI_ARADDR,
    output logic [2:0]                          M_AXI_ARPROT,
    output logic                                M_AXI_ARVALID,
    input  logic                                M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]       M_AXI_RDATA,
    input  logic [1:0]                          M_AXI_RRESP,
    input  logic                                M_AXI_RVALID,
    output logic                                M_AXI_RREADY
);

    localparam int IDX_W = idx_width(NUM_REGS);
    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t                  state;
    logic                    state_chg;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_nxt;
    logic [NUM_REGS*32-1:0]  shadow;
    logic                    tmo_active;
    logic                    tmo_expired;

    function automatic logic [AW-1:0] reg_addr(input logic [IDX_W-1:0] i);
        return AW'(BASE_ADDR + 4 * int'(i));
    endfunction

    assign idx_nxt    = idx + 1'b1;
    assign tmo_active = state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    pmod_cfg_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .clr     (state_chg),
        .en      (tmo_active),
        .expired (tmo_expired)
    );

`ifndef PMOD_CFG_VERIFY_EN
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b0;

    logic unused_rd;
    assign unused_rd = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

    // state_chg marks the first cycle of every state so the watchdog restarts
    // its count on each phase change.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            state_chg     <= 1'b0;
            idx           <= '0;
            shadow        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_code      <= ERR_NONE;
            err_idx       <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
`ifdef PMOD_CFG_VERIFY_EN
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
`endif
        end else begin
            state_chg <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        shadow        <= cfg_data;
                        err_code      <= ERR_NONE;
                        err_idx       <= '0;
                        idx           <= '0;
                        busy          <= 1'b1;
                        M_AXI_AWADDR  <= reg_addr('0);
                        M_AXI_WDATA   <= cfg_data[31:0];
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= WR_REQ;
                        state_chg     <= 1'b1;
                    end
                end

                WR_REQ: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    // Each channel is finished once its VALID has already
                    // dropped or is being accepted on this edge.
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) &&
                        (!M_AXI_WVALID  || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_RESP;
                        state_chg    <= 1'b1;
                    end
                end

                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        state_chg    <= 1'b1;
                        if (M_AXI_BRESP != AXI_RESP_OKAY) begin
                            err_code <= ERR_RESP;
                            err_idx  <= idx;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end else if (idx == LAST_IDX) begin
`ifdef PMOD_CFG_VERIFY_EN
                            idx           <= '0;
                            M_AXI_ARADDR  <= reg_addr('0);
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_REQ;
`else
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
`endif
                        end else begin
                            idx           <= idx_nxt;
                            M_AXI_AWADDR  <= reg_addr(idx_nxt);
                            M_AXI_WDATA   <= shadow[32*idx_nxt +: 32];
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WR_REQ;
                        end
                    end
                end

`ifdef PMOD_CFG_VERIFY_EN
                RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_RESP;
                        state_chg     <= 1'b1;
                    end
                end

                RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        state_chg    <= 1'b1;
                        if (M_AXI_RRESP != AXI_RESP_OKAY) begin
                            err_code <= ERR_RESP;
                            err_idx  <= idx;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end else if (M_AXI_RDATA != shadow[32*idx +: 32]) begin
                            err_code <= ERR_MISMATCH;
                            err_idx  <= idx;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end else if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            idx           <= idx_nxt;
                            M_AXI_ARADDR  <= reg_addr(idx_nxt);
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_REQ;
                        end
                    end
                end
`endif

                FINISH: begin
                    state     <= IDLE;
                    state_chg <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    state_chg <= 1'b1;
                end
            endcase

            // A stalled phase overrides whatever the case above decided.
            if (tmo_expired) begin
                err_code      <= ERR_TIMEOUT;
                err_idx       <= idx;
                M_AXI_AWVALID <= 1'b0;
                M_AXI_WVALID  <= 1'b0;
                M_AXI_BREADY  <= 1'b0;
`ifdef PMOD_CFG_VERIFY_EN
                M_AXI_ARVALID <= 1'b0;
                M_AXI_RREADY  <= 1'b0;
`endif
                busy          <= 1'b0;
                done          <= 1'b1;
                state         <= FINISH;
                state_chg     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pmod_cfg_sequencer.sv
module tb_pmod_cfg_sequencer;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

`ifdef PMOD_CFG_VERIFY_EN
    localparam int RD_CYC = 8;
`else
    localparam int RD_CYC = 0;
`endif

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         start;
    logic [127:0] cfg_data;
    logic         busy, done;
    logic [1:0]   err_code, err_idx;
    logic [3:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic         awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic         arready = 1'b0, rvalid = 1'b0;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp = 2'b00, rresp = 2'b00;
    logic [31:0]  rdata = 32'h0;

    int errors = 0;
    int checks = 0;

    // slave knobs (written only by the stimulus)
    int aw_delay = 0, w_delay = 0, bad_b_idx = -1, bad_r_idx = -1;
    bit b_never = 1'b0;

    // slave counters (written only by the slave model)
    int wr_cnt = 0, b_cnt = 0, aw_hi = 0, w_hi = 0, br_hi = 0;

    wr_t exp_q[$];

    always #5 aclk = ~aclk;

    pmod_cfg_sequencer dut (
        .ACLK          (aclk),
        .ARESETN       (aresetn),
        .start         (start),
        .cfg_data      (cfg_data),
        .busy          (busy),
        .done          (done),
        .err_code      (err_code),
        .err_idx       (err_idx),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // AXI4-Lite slave model: readies/responses change on the falling edge,
    // handshakes are the ones the DUT sees on the following rising edge.
    logic       aw_got = 0, w_got = 0, b_pend = 0;
    logic       aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int         aw_cnt = 0, w_cnt = 0;
    logic [3:0] cap_awaddr = 0;
    logic [31:0] cap_wdata = 0;
    logic [1:0] cap_ar = 0, b_reg = 0;
    logic [31:0] mem [4];

    always @(negedge aclk) begin : slave
        wr_t e;
        if (aw_hs) aw_got = 1'b1;
        if (w_hs)  w_got  = 1'b1;
        if (b_hs) begin b_cnt++; bvalid = 1'b0; end
        if (r_hs) rvalid = 1'b0;
        if (ar_hs) begin
            rvalid = 1'b1;
            rresp  = 2'b00;
            rdata  = (int'(cap_ar) == bad_r_idx) ? 32'h0000_DEAD : mem[cap_ar];
        end
        if (awvalid) aw_hi++;
        if (wvalid)  w_hi++;
        if (bready)  br_hi++;
        if (aw_got && w_got) begin
            wr_cnt++;
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(cap_awaddr), 32'(e.addr));
                chk("wr_data", cap_wdata, e.data);
            end
            mem[cap_awaddr[3:2]] = cap_wdata;
            b_reg  = cap_awaddr[3:2];
            b_pend = 1'b1;
            aw_got = 1'b0;
            w_got  = 1'b0;
        end
        if (!aresetn || !busy) begin
            aw_got = 0; w_got = 0; b_pend = 0; bvalid = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0;
        end
        awready = awvalid && (aw_cnt >= aw_delay);
        if (awvalid && !awready) aw_cnt++;
        if (awready) begin cap_awaddr = awaddr; aw_cnt = 0; end
        wready = wvalid && (w_cnt >= w_delay);
        if (wvalid && !wready) w_cnt++;
        if (wready) begin cap_wdata = wdata; w_cnt = 0; end
        if (b_pend && !b_never) begin
            bvalid = 1'b1;
            bresp  = (int'(b_reg) == bad_b_idx) ? 2'b10 : 2'b00;
            b_pend = 1'b0;
        end
        arready = arvalid && !rvalid;
        if (arready) cap_ar = araddr[3:2];
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
    end

    // Drive start for one cycle and queue the writes expected from it.
    task automatic kick(input logic [127:0] cfg, input int n);
        @(negedge aclk);
        cfg_data = cfg;
        start    = 1'b1;
        for (int i = 0; i < n; i++)
            exp_q.push_back('{addr: 4'(i * 4), data: cfg[32*i +: 32]});
        @(negedge aclk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("err_cleared_on_start", 32'(err_code), 32'd0);
    endtask

    // Cycle count is relative to the start cycle (done seen in cycle lat).
    task automatic wait_done(input int max_cyc, output int lat);
        lat = 0;
        for (int i = 2; i <= max_cyc && lat == 0; i++) begin
            @(negedge aclk);
            if (done === 1'b1) lat = i;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic after_done();
        @(negedge aclk);
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("busy_low", 32'(busy), 32'd0);
    endtask

    function automatic logic [127:0] rand_cfg();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int lat;
        int wr0, b0, aw0, w0, br0;
        logic [127:0] cfg;

        aresetn  = 1'b0;
        start    = 1'b0;
        cfg_data = '0;
        repeat (3) @(negedge aclk);

        // reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_err_idx", 32'(err_idx), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_awaddr", 32'(awaddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("awprot", 32'(awprot), 32'd0);
        chk("arprot", 32'(arprot), 32'd0);
        chk("wstrb", 32'(wstrb), 32'hF);
        aresetn = 1'b1;

        // zero-wait slave, cfg = {4,3,2,1}
        cfg = {32'd4, 32'd3, 32'd2, 32'd1};
        wr0 = wr_cnt;
        kick(cfg, 4);
        wait_done(60, lat);
        chk("t1_latency", lat, 9 + RD_CYC);
        chk("t1_err_code", 32'(err_code), 32'd0);
        after_done();
        chk("t1_writes", wr_cnt - wr0, 4);
        chk("t1_queue_empty", exp_q.size(), 0);

        // AWREADY delayed, WREADY immediate
        aw_delay = 2;
        cfg = rand_cfg();
        wr0 = wr_cnt; b0 = b_cnt; aw0 = aw_hi; w0 = w_hi; br0 = br_hi;
        kick(cfg, 4);
        wait_done(80, lat);
        chk("t2_latency", lat, 17 + RD_CYC);
        chk("t2_err_code", 32'(err_code), 32'd0);
        after_done();
        chk("t2_awvalid_cycles", aw_hi - aw0, 12);
        chk("t2_wvalid_cycles", w_hi - w0, 4);
        chk("t2_b_handshakes", b_cnt - b0, 4);
        chk("t2_bready_cycles", br_hi - br0, 4);
        chk("t2_writes", wr_cnt - wr0, 4);

        // WREADY delayed, AWREADY immediate
        aw_delay = 0;
        w_delay  = 3;
        cfg = rand_cfg();
        aw0 = aw_hi; w0 = w_hi;
        kick(cfg, 4);
        wait_done(80, lat);
        chk("t2b_latency", lat, 21 + RD_CYC);
        after_done();
        chk("t2b_awvalid_cycles", aw_hi - aw0, 4);
        chk("t2b_wvalid_cycles", w_hi - w0, 16);
        chk("t2b_queue_empty", exp_q.size(), 0);
        w_delay = 0;

        // SLVERR on register 2 aborts before register 3
        bad_b_idx = 2;
        cfg = rand_cfg();
        wr0 = wr_cnt;
        kick(cfg, 3);
        wait_done(60, lat);
        chk("t3_latency", lat, 7);
        chk("t3_err_code", 32'(err_code), 32'd1);
        chk("t3_err_idx", 32'(err_idx), 32'd2);
        after_done();
        repeat (4) @(negedge aclk);
        chk("t3_writes", wr_cnt - wr0, 3);
        chk("t3_queue_empty", exp_q.size(), 0);
        chk("t3_err_code_held", 32'(err_code), 32'd1);
        chk("t3_err_idx_held", 32'(err_idx), 32'd2);
        bad_b_idx = -1;

        // BVALID never arrives -> timeout in WR_RESP
        b_never = 1'b1;
        cfg = rand_cfg();
        kick(cfg, 1);
        wait_done(400, lat);
        chk("t4_latency", lat, 258);
        chk("t4_err_code", 32'(err_code), 32'd3);
        chk("t4_err_idx", 32'(err_idx), 32'd0);
        after_done();
        chk("t4_awvalid", 32'(awvalid), 32'd0);
        chk("t4_wvalid", 32'(wvalid), 32'd0);
        chk("t4_bready", 32'(bready), 32'd0);
        b_never = 1'b0;
        cfg = rand_cfg();
        kick(cfg, 4);
        wait_done(60, lat);
        chk("t4_restart_latency", lat, 9 + RD_CYC);
        chk("t4_restart_err_code", 32'(err_code), 32'd0);
        after_done();
        chk("t4_queue_empty", exp_q.size(), 0);

        // asynchronous reset while AWVALID is stalled
        aw_delay = 5;
        cfg = rand_cfg();
        kick(cfg, 4);
        @(negedge aclk);
        chk("t5_awvalid_before", 32'(awvalid), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("t5_awvalid_async", 32'(awvalid), 32'd0);
        chk("t5_wvalid_async", 32'(wvalid), 32'd0);
        chk("t5_bready_async", 32'(bready), 32'd0);
        chk("t5_busy_async", 32'(busy), 32'd0);
        chk("t5_no_write_done", exp_q.size(), 4);
        exp_q.delete();
        repeat (2) @(negedge aclk);
        aresetn  = 1'b1;
        aw_delay = 0;
        cfg = rand_cfg();
        kick(cfg, 4);
        wait_done(60, lat);
        chk("t5_latency", lat, 9 + RD_CYC);
        chk("t5_err_code", 32'(err_code), 32'd0);
        after_done();
        chk("t5_queue_empty", exp_q.size(), 0);

`ifdef PMOD_CFG_VERIFY_EN
        // readback of register 1 returns 0xDEAD
        bad_r_idx = 1;
        cfg = rand_cfg();
        cfg[63:32] = 32'h1234_5678;
        kick(cfg, 4);
        wait_done(60, lat);
        chk("t6_latency", lat, 13);
        chk("t6_err_code", 32'(err_code), 32'd2);
        chk("t6_err_idx", 32'(err_idx), 32'd1);
        after_done();
        bad_r_idx = -1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
